k_dsp_alu_pipe: RTL and testbench
=================================

// Module: k_dsp_alu_pipe
// PURPOSE
//  Parametrised, pipelined successor to the combinational K_ALU datapath for the K_DSP core.
//  Signed two's-complement ALU: opcode select, optional saturation, internal MAC accumulator.
//  Valid/ready handshake on both sides. Sits between operand fetch and writeback/result FIFO.
// PARAMETERS
//  WIDTH     32  operand/result width in bits (>=8)
//  SAT_EN    1   1: ADD/SUB/MUL/MAC saturate to signed range; 0: wrap modulo 2^WIDTH
//  ACC_GUARD 8   extra accumulator guard bits above WIDTH (internal acc is WIDTH+ACC_GUARD)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  op         in   3      opcode (see BEHAVIOUR)
//  opA        in   WIDTH  signed operand A
//  opB        in   WIDTH  signed operand B
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  result     out  WIDTH  signed result
//  ovf        out  1      saturation/overflow occurred for this beat
// BEHAVIOUR
//  Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 MAC, 4 AND, 5 OR, 6 XOR, 7 ACLR.
//  Pipeline: S1 registers op/opA/opB; S2 computes and registers result/ovf. Latency = 2 cycles.
//  Handshake: beat accepted when in_valid && in_ready. Beat delivered when out_valid && out_ready.
//  Flow control: adv = !out_valid || out_ready; in_ready = adv; both stages move only when adv.
//  Full throughput, 1 beat/cycle, when out_ready stays high.
//  Stall: out_ready low holds result/ovf/out_valid stable; no bubbles, no drops, order preserved.
//  in_ready depends on out_ready combinationally; no other combinational in->out path.
//  Arithmetic: full-precision result, then SAT_EN clamps to [-2^(W-1), 2^(W-1)-1].
//   - ovf=1 when clamping occurs; with SAT_EN=0, ovf=1 on wrap and result is the low WIDTH bits.
//   - MUL: full 2W product, then saturate or take low WIDTH bits.
//   - Logic ops: ovf=0.
//  MAC: acc <= acc + opA*opB, at WIDTH+ACC_GUARD precision.
//   - Acc saturates at its own width, never wraps.
//   - result = acc saturated to WIDTH (SAT_EN=1) or low WIDTH bits (SAT_EN=0).
//   - ovf = WIDTH clamp/wrap.
//   - acc updates in S2, only when the beat advances into S2.
//   - Back-to-back MACs chain with no hazard.
//  ACLR: acc <= 0, result = 0, ovf = 0. Other ops leave acc unchanged.
//  Reset: out_valid=0, result=0, ovf=0, acc=0, both stage valids=0; in_ready=1 the cycle after.
//  Reset mid-operation: all in-flight beats are discarded and not delivered.
//  Input beats offered while rst=1 are ignored.
//  Boundaries: -2^(W-1) * -1 (MUL) saturates to max with ovf=1.
//  Boundaries: SUB of min-1 clamps to min with ovf=1.
// STRUCTURE
//  Package k_dsp_pkg: opcode localparams (K_OP_ADD..K_OP_ACLR), opcode width.
//  Package k_dsp_pkg: sat_clamp function for signed saturation.
//  Sub-module k_dsp_sat: generic signed saturator.
//   - Params IN_W, OUT_W, EN. Outputs clamped value + ovf.
//   - Instantiated twice: WIDTH clamp and accumulator clamp.
//  Top holds S1/S2 registers, acc register, handshake logic and op mux.
// TESTING (WIDTH=32, SAT_EN=1 unless stated)
//  ADD 10,20 with out_ready=1 -> result=30, ovf=0, out_valid exactly 2 cycles after accept.
//  ADD 0x7FFFFFFF,1 -> 0x7FFFFFFF, ovf=1.
//  Same ADD with SAT_EN=0 -> 0x80000000, ovf=1.
//  ACLR, then MAC (3,4), MAC (5,6), MAC (-2,10) -> results 0, 12, 42, 22, all ovf=0.
//  Stream 5 ADDs, hold out_ready=0 for 4 cycles -> in_ready low within 1 cycle.
//   Result held stable during stall; all 5 sums delivered in order, none lost/duplicated.
//  Fill both stages, assert rst 1 cycle -> out_valid=0 next cycle, nothing delivered, acc=0.
//   Next MAC (2,3) -> 6.
//  MUL 0x80000000,0xFFFFFFFF -> 0x7FFFFFFF, ovf=1.
//  XOR 0xF0F0F0F0,0xFFFF0000 -> 0x0F0FF0F0, ovf=0.

Source files
------------

// File: rtl/k_dsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : k_dsp_pkg
//  Description : Shared opcode encodings and signed saturation helper for the
//                K_DSP pipelined ALU datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package k_dsp_pkg;

    localparam int K_OP_W = 3;

    localparam logic [K_OP_W-1:0] K_OP_ADD  = 3'd0;
    localparam logic [K_OP_W-1:0] K_OP_SUB  = 3'd1;
    localparam logic [K_OP_W-1:0] K_OP_MUL  = 3'd2;
    localparam logic [K_OP_W-1:0] K_OP_MAC  = 3'd3;
    localparam logic [K_OP_W-1:0] K_OP_AND  = 3'd4;
    localparam logic [K_OP_W-1:0] K_OP_OR   = 3'd5;
    localparam logic [K_OP_W-1:0] K_OP_XOR  = 3'd6;
    localparam logic [K_OP_W-1:0] K_OP_ACLR = 3'd7;

    // Working width of the clamp helper; any saturator input must be narrower.
    localparam int K_SAT_MAX_W = 256;

    // Clamp a sign-extended value to the signed range of an out_w-bit number.
    // The clamped value is returned still sign-extended to K_SAT_MAX_W.
    function automatic logic signed [K_SAT_MAX_W-1:0] sat_clamp(
        input logic signed [K_SAT_MAX_W-1:0] val,
        input int                            out_w
    );
        logic signed [K_SAT_MAX_W-1:0] one;
        logic signed [K_SAT_MAX_W-1:0] hi;
        logic signed [K_SAT_MAX_W-1:0] lo;
        one = {{(K_SAT_MAX_W-1){1'b0}}, 1'b1};
        hi  = (one <<< (out_w - 1)) - one;
        lo  = ~hi;
        if (val > hi) begin
            return hi;
        end
        if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage : k_dsp_pkg
`default_nettype wire

// File: rtl/k_dsp_sat.sv
`default_nettype none
// ============================================================================
//  Module      : k_dsp_sat
//  Description : Generic signed narrowing stage. EN!=0 clamps to the OUT_W
//                signed range, EN==0 keeps the low OUT_W bits. o_ovf flags
//                any input that does not fit OUT_W signed bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module k_dsp_sat
    import k_dsp_pkg::*;
#(
    parameter int IN_W  = 33,
    parameter int OUT_W = 32,
    parameter int EN    = 1
) (
    input  logic [IN_W-1:0]  i_din,
    output logic [OUT_W-1:0] o_dout,
    output logic             o_ovf
);

    logic signed [K_SAT_MAX_W-1:0] w_ext;
    logic signed [K_SAT_MAX_W-1:0] w_clamped;

    assign w_ext     = {{(K_SAT_MAX_W-IN_W){i_din[IN_W-1]}}, i_din};
    assign w_clamped = sat_clamp(w_ext, OUT_W);
    // Any change made by the clamp means the value was out of range.
    assign o_ovf     = (w_clamped != w_ext);

    generate
        if (EN != 0) begin : g_sat
            assign o_dout = w_clamped[OUT_W-1:0];
        end else begin : g_wrap
            assign o_dout = i_din[OUT_W-1:0];
        end
    endgenerate

endmodule : k_dsp_sat
`default_nettype wire

// File: rtl/k_dsp_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : k_dsp_alu_pipe
//  Description : Two-stage pipelined signed ALU with optional saturation and
//                an internal guarded MAC accumulator. Valid/ready on both
//                sides; both stages advance together when the output slot
//                is empty or being drained.
//  Revision    : 1.0 - initial release
// ============================================================================
module k_dsp_alu_pipe
    import k_dsp_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SAT_EN    = 1,
    parameter int ACC_GUARD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [K_OP_W-1:0] op,
    input  logic [WIDTH-1:0]  opA,
    input  logic [WIDTH-1:0]  opB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              ovf
);

    localparam int ACC_W  = WIDTH + ACC_GUARD;
    localparam int PROD_W = 2 * WIDTH;
    // One bit above the widest of product and accumulator so acc+product
    // and every add/sub are exact before narrowing.
    localparam int FULL_W = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

    // Stage 1 operand registers
    logic              r_s1_valid;
    logic [K_OP_W-1:0] r_s1_op;
    logic [WIDTH-1:0]  r_s1_a;
    logic [WIDTH-1:0]  r_s1_b;

    // Stage 2 result registers and accumulator
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_result;
    logic              r_ovf;
    logic [ACC_W-1:0]  r_acc;

    logic                     w_adv;
    logic signed [FULL_W-1:0] w_a_ext;
    logic signed [FULL_W-1:0] w_b_ext;
    logic signed [FULL_W-1:0] w_acc_ext;
    logic signed [FULL_W-1:0] w_prod;
    logic signed [FULL_W-1:0] w_mac_sum;
    logic        [ACC_W-1:0]  w_acc_next;
    logic                     w_acc_ovf;
    logic signed [FULL_W-1:0] w_full;
    logic        [WIDTH-1:0]  w_res;
    logic                     w_res_ovf;
    logic                     w_is_mac;
    logic                     w_ovf_next;

    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign ovf       = r_ovf;

    assign w_a_ext   = {{(FULL_W-WIDTH){r_s1_a[WIDTH-1]}}, r_s1_a};
    assign w_b_ext   = {{(FULL_W-WIDTH){r_s1_b[WIDTH-1]}}, r_s1_b};
    assign w_acc_ext = {{(FULL_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_mac_sum = w_acc_ext + w_prod;
    assign w_is_mac  = (r_s1_op == K_OP_MAC);

    // Accumulator always saturates at its own width, whatever SAT_EN says.
    k_dsp_sat #(
        .IN_W  (FULL_W),
        .OUT_W (ACC_W),
        .EN    (1)
    ) u_acc_sat (
        .i_din  (w_mac_sum),
        .o_dout (w_acc_next),
        .o_ovf  (w_acc_ovf)
    );

    // Full-precision op mux feeding the result-width narrowing stage.
    always_comb begin
        w_full = '0;
        case (r_s1_op)
            K_OP_ADD:  w_full = w_a_ext + w_b_ext;
            K_OP_SUB:  w_full = w_a_ext - w_b_ext;
            K_OP_MUL:  w_full = w_prod;
            K_OP_MAC:  w_full = {{(FULL_W-ACC_W){w_acc_next[ACC_W-1]}}, w_acc_next};
            K_OP_AND:  w_full = w_a_ext & w_b_ext;
            K_OP_OR:   w_full = w_a_ext | w_b_ext;
            K_OP_XOR:  w_full = w_a_ext ^ w_b_ext;
            K_OP_ACLR: w_full = '0;
            default:   w_full = '0;
        endcase
    end

    k_dsp_sat #(
        .IN_W  (FULL_W),
        .OUT_W (WIDTH),
        .EN    (SAT_EN)
    ) u_res_sat (
        .i_din  (w_full),
        .o_dout (w_res),
        .o_ovf  (w_res_ovf)
    );

    // Logic ops and ACLR sign-extend cleanly, so w_res_ovf is already 0 for
    // them; a MAC also reports an accumulator clamp (matters when ACC_GUARD=0).
    assign w_ovf_next = w_res_ovf | (w_is_mac & w_acc_ovf);

    // Stage 1: capture the offered beat whenever the pipe advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op <= op;
                r_s1_a  <= opA;
                r_s1_b  <= opB;
            end
        end
    end

    // Stage 2: register result/ovf and commit accumulator side effects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_acc       <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_res;
                r_ovf    <= w_ovf_next;
                if (w_is_mac) begin
                    r_acc <= w_acc_next;
                end else if (r_s1_op == K_OP_ACLR) begin
                    r_acc <= '0;
                end
            end
        end
    end

endmodule : k_dsp_alu_pipe
`default_nettype wire

// File: tb/tb_k_dsp_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_k_dsp_alu_pipe
//  Description : Directed self-checking bench for k_dsp_alu_pipe. A saturating
//                and a wrapping instance share all inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_k_dsp_alu_pipe;
    import k_dsp_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_ready_w;
    logic [K_OP_W-1:0] op;
    logic [31:0]       opA;
    logic [31:0]       opB;
    logic              out_valid;
    logic              out_valid_w;
    logic              out_ready;
    logic [31:0]       result;
    logic [31:0]       result_w;
    logic              ovf;
    logic              ovf_w;

    int n_checks;
    int n_fail;

    k_dsp_alu_pipe #(.WIDTH(32), .SAT_EN(1), .ACC_GUARD(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .opA(opA), .opB(opB), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .ovf(ovf)
    );

    k_dsp_alu_pipe #(.WIDTH(32), .SAT_EN(0), .ACC_GUARD(8)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .op(op), .opA(opA), .opB(opB), .out_valid(out_valid_w),
        .out_ready(out_ready), .result(result_w), .ovf(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Single isolated beat with out_ready high; result is visible on return.
    task automatic beat(input logic [K_OP_W-1:0] o, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; op = o; opA = a; opB = b;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; opA = '0; opB = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tick();
    endtask

    task automatic test_add_latency;
        out_ready = 1'b1;
        in_valid = 1'b1; op = K_OP_ADD; opA = 32'd10; opB = 32'd20;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_accept in_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_lat1 out_valid got=%b exp=0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_lat2 out_valid got=%b exp=1", out_valid); end
        n_checks++; if (result !== 32'd30) begin n_fail++; $display("FAIL add_result got=%h exp=%h", result, 32'd30); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL add_ovf got=%b exp=0", ovf); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_add_sat;
        beat(K_OP_ADD, 32'h7FFF_FFFF, 32'h1);
        n_checks++; if (result !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL addsat_result got=%h exp=7fffffff", result); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL addsat_ovf got=%b exp=1", ovf); end
        n_checks++; if (result_w !== 32'h8000_0000) begin n_fail++; $display("FAIL addwrap_result got=%h exp=80000000", result_w); end
        n_checks++; if (ovf_w !== 1'b1) begin n_fail++; $display("FAIL addwrap_ovf got=%b exp=1", ovf_w); end
    endtask

    task automatic test_logic;
        beat(K_OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000);
        n_checks++; if (result !== 32'h0F0F_F0F0) begin n_fail++; $display("FAIL xor_result got=%h exp=0f0ff0f0", result); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL xor_ovf got=%b exp=0", ovf); end
        beat(K_OP_AND, 32'hF0F0_F0F0, 32'hFFFF_0000);
        n_checks++; if (result !== 32'hF0F0_0000) begin n_fail++; $display("FAIL and_result got=%h exp=f0f00000", result); end
        beat(K_OP_OR, 32'hF0F0_F0F0, 32'hFFFF_0000);
        n_checks++; if (result !== 32'hFFFF_F0F0) begin n_fail++; $display("FAIL or_result got=%h exp=fffff0f0", result); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL or_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_boundaries;
        beat(K_OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF);
        n_checks++; if (result !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL mulsat_result got=%h exp=7fffffff", result); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL mulsat_ovf got=%b exp=1", ovf); end
        n_checks++; if (result_w !== 32'h8000_0000) begin n_fail++; $display("FAIL mulwrap_result got=%h exp=80000000", result_w); end
        beat(K_OP_MUL, 32'hFFFF_FFFD, 32'd7);
        n_checks++; if (result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_neg_result got=%h exp=ffffffeb", result); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL mul_neg_ovf got=%b exp=0", ovf); end
        beat(K_OP_SUB, 32'h8000_0000, 32'h1);
        n_checks++; if (result !== 32'h8000_0000) begin n_fail++; $display("FAIL subsat_result got=%h exp=80000000", result); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL subsat_ovf got=%b exp=1", ovf); end
        n_checks++; if (result_w !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL subwrap_result got=%h exp=7fffffff", result_w); end
        beat(K_OP_SUB, 32'd5, 32'd9);
        n_checks++; if (result !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL sub_result got=%h exp=fffffffc", result); end
    endtask

    task automatic test_mac;
        beat(K_OP_ACLR, 32'h1234, 32'h5678);
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL aclr_result got=%h exp=0", result); end
        beat(K_OP_MAC, 32'd3, 32'd4);
        n_checks++; if (result !== 32'd12) begin n_fail++; $display("FAIL mac1_result got=%h exp=%h", result, 32'd12); end
        beat(K_OP_MAC, 32'd5, 32'd6);
        n_checks++; if (result !== 32'd42) begin n_fail++; $display("FAIL mac2_result got=%h exp=%h", result, 32'd42); end
        beat(K_OP_MAC, 32'hFFFF_FFFE, 32'd10);
        n_checks++; if (result !== 32'd22) begin n_fail++; $display("FAIL mac3_result got=%h exp=%h", result, 32'd22); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL mac3_ovf got=%b exp=0", ovf); end
        beat(K_OP_ADD, 32'd1, 32'd1);
        beat(K_OP_MAC, 32'd0, 32'd0);
        n_checks++; if (result !== 32'd22) begin n_fail++; $display("FAIL mac_keep_result got=%h exp=%h", result, 32'd22); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        in_valid = 1'b1; op = K_OP_ACLR; opA = 32'd0; opB = 32'd0;
        tick();
        op = K_OP_MAC; opA = 32'd1; opB = 32'd1;
        tick();
        n_checks++; if (out_valid !== 1'b1 || result !== 32'd0) begin n_fail++; $display("FAIL b2b_aclr valid=%b got=%h exp=0", out_valid, result); end
        opA = 32'd2; opB = 32'd2;
        tick();
        n_checks++; if (out_valid !== 1'b1 || result !== 32'd1) begin n_fail++; $display("FAIL b2b_mac1 valid=%b got=%h exp=1", out_valid, result); end
        opA = 32'd3; opB = 32'd3;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || result !== 32'd5) begin n_fail++; $display("FAIL b2b_mac2 valid=%b got=%h exp=5", out_valid, result); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || result !== 32'd14) begin n_fail++; $display("FAIL b2b_mac3 valid=%b got=%h exp=14", out_valid, result); end
        tick();
    endtask

    task automatic test_stall;
        logic [31:0] got[$];
        int          sent;
        int          c;
        logic        prev_stall;
        logic [31:0] prev_res;
        sent = 0; c = 0; prev_stall = 1'b0; prev_res = '0;
        while (got.size() < 5 && c < 40) begin
            out_ready = !(c >= 3 && c < 7);
            in_valid  = (sent < 5);
            op        = K_OP_ADD;
            opA       = 32'(1000 + sent);
            opB       = 32'(3 * sent);
            #1;
            if (prev_stall) begin
                n_checks++; if (out_valid !== 1'b1 || result !== prev_res) begin n_fail++; $display("FAIL stall_hold c=%0d valid=%b got=%h exp=%h", c, out_valid, result, prev_res); end
            end
            if (c == 3) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
            end
            if (out_valid && out_ready) got.push_back(result);
            if (in_valid && in_ready) sent++;
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
            tick();
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (got.size() != 5) begin n_fail++; $display("FAIL stall_count got=%0d exp=5", got.size()); end
        foreach (got[k]) begin
            n_checks++; if (got[k] !== 32'(1000 + 4 * k)) begin n_fail++; $display("FAIL stall_order idx=%0d got=%h exp=%h", k, got[k], 32'(1000 + 4 * k)); end
        end
        tick(); tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_extra out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        out_ready = 1'b0;
        in_valid = 1'b1; op = K_OP_MAC; opA = 32'd7; opB = 32'd7;
        tick();
        op = K_OP_ADD; opA = 32'd1; opB = 32'd1;
        tick();
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_fill valid=%b ready=%b exp=1/0", out_valid, in_ready); end
        rst = 1'b1; op = K_OP_ADD; opA = 32'd5; opB = 32'd5; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_delivered got=%0d exp=0", seen); end
        beat(K_OP_MAC, 32'd2, 32'd3);
        n_checks++; if (result !== 32'd6) begin n_fail++; $display("FAIL rstmid_mac got=%h exp=6", result); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_mac_ovf got=%b exp=0", ovf); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add_latency();
        test_add_sat();
        test_logic();
        test_boundaries();
        test_mac();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_k_dsp_alu_pipe
`default_nettype wire
